uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 4, the bit_counter width.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 5, the Prescale/sample_counter width.
REQ-003 SHALL have ports as follows; one clock; reset is synchronous and active-high:
- CLK  in  1  UART RX oversampling clock
- RST  in  1  synchronous active-high reset
- RX_IN  in  1  serial line, idle high
- PAR_EN  in  1  parity bit present in frame
- Prescale  in  PRESCALE_WIDTH  oversampling ratio; 8 or 16 only
- bit_counter  in  COUNTER_WIDTH  from edge counter
- sample_counter  in  PRESCALE_WIDTH  from edge counter
- strt_glitch  in  1  start checker: sampled start bit was 1
- par_err  in  1  parity checker error
- stp_err  in  1  stop checker error
- edge_cnt_clr  out  1  edge counter clear; counter runs while 0
- dat_samp_en  out  1  data sampler enable
- deser_en  out  1  deserializer shift strobe
- strt_chk_en / par_chk_en / stp_chk_en  out  1 each  checker strobes
- data_valid  out  1  error-free byte ready, 1-cycle pulse
- frame_err  out  1  1-cycle pulse, stop bit error
- parity_err  out  1  1-cycle pulse, parity error

Function
REQ-004 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE; state registered, outputs decoded from state and counters.
REQ-005 SHALL define bit end (BE) as sample_counter == Prescale-1; sample point (SP) as sample_counter == (Prescale>>1)+2 (6 for Prescale 8, 10 for 16); all comparisons PRESCALE_WIDTH wide.
REQ-006 IDLE: RX_IN==0 -> START next cycle; else remain.
REQ-007 SHALL latch PAR_EN into par_en_q on IDLE->START and DONE->START only; mid-frame PAR_EN changes SHALL be ignored.
REQ-008 START: at BE with bit_counter==0 -> IDLE if strt_glitch==1, else DATA.
REQ-009 DATA: at BE with bit_counter==8 -> PARITY if par_en_q, else STOP.
REQ-010 PARITY: at BE with bit_counter==9 -> STOP.
REQ-011 STOP: at BE with bit_counter==9+par_en_q -> DONE.
REQ-012 DONE: lasts exactly 1 cycle; RX_IN==0 -> START (back-to-back frame), else IDLE.
REQ-013 edge_cnt_clr SHALL be 1 in IDLE and DONE, 0 otherwise; dat_samp_en SHALL be 1 in START, DATA, PARITY, STOP.
REQ-014 deser_en, strt_chk_en, par_chk_en, stp_chk_en SHALL each pulse 1 cycle at SP in DATA, START, PARITY, STOP respectively; 0 elsewhere.
REQ-015 SHALL capture par_err (PARITY state) and stp_err (STOP state) into sticky flags from SP+1 through BE; flags clear on entry to START.
REQ-016 In DONE: data_valid=1 iff both flags 0; parity_err=parity flag; frame_err=stop flag; all three 0 in every other state.
REQ-017 Checker inputs SHALL be ignored outside their own state.
REQ-018 Unsupported Prescale values: behaviour unspecified, but FSM SHALL return to IDLE by BE with bit_counter > 11 (deadlock guard) from any non-IDLE state.

Reset
REQ-019 RST==1 at posedge CLK SHALL force state IDLE, par_en_q=0, both flags 0; outputs then edge_cnt_clr=1, all others 0.
REQ-020 RST mid-frame SHALL abort the frame with no data_valid/error pulse; next frame decoded normally.

Structure
REQ-021 State encoding localparams, DATA_BITS=8, START_BIT_IDX=0 SHALL live in shared package uart_rx_pkg.
REQ-022 Single module, no sub-module; two processes: registered state/flags, combinational next-state/outputs.

Verification
REQ-023 Prescale=8, PAR_EN=0, frame 0xA5 -> 8 deser_en pulses at sample_counter=6, one data_valid, no errors.
REQ-024 Prescale=16, PAR_EN=1, even-parity error injected (par_err=1 at SP) -> parity_err pulse, data_valid=0.
REQ-025 RX_IN low for 3 cycles then high, strt_glitch=1 -> return to IDLE at first BE, no deser_en pulses.
REQ-026 Two back-to-back frames 0x00, 0xFF, RX_IN=0 during DONE -> DONE->START directly, two data_valid pulses.
REQ-027 stp_err=1 at STOP SP -> frame_err pulse in DONE, data_valid=0; PAR_EN toggled mid-frame -> frame length unchanged.
REQ-028 RST asserted in DATA at bit_counter=4 -> IDLE next cycle, edge_cnt_clr=1, no output pulses.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared constants for the UART receive path: FSM state encoding and the
// bit-index landmarks of a frame (start, data, parity/stop).
// No ports; imported by uart_rx_ctrl.
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    // FSM state encoding, kept as plain constants so older tools and
    // waveform scripts that decode the raw state value keep working.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Frame layout in bit_counter units: start bit is index 0, data bits
    // are 1..DATA_BITS, the optional parity bit follows, then the stop bit.
    localparam int DATA_BITS      = 8;
    localparam int START_BIT_IDX  = 0;
    localparam int PARITY_BIT_IDX = DATA_BITS + 1;

    // Any bit index above this means the frame has run away (unsupported
    // Prescale); the controller bails out to IDLE.
    localparam int GUARD_BIT_IDX  = 11;

endpackage

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side frame controller for a UART. Tracks the frame with an FSM
// (IDLE, START, DATA, PARITY, STOP, DONE) driven by an external edge counter,
// and strobes the sampler, deserializer and checkers at the sample point of
// each bit. Reports one result pulse per completed frame.
//
// Ports
//   CLK            in   oversampling clock
//   RST            in   synchronous active-high reset
//   RX_IN          in   serial line, idle high
//   PAR_EN         in   parity bit present (latched at frame start)
//   Prescale       in   oversampling ratio (8 or 16)
//   bit_counter    in   bit index from the edge counter
//   sample_counter in   sample index within the bit from the edge counter
//   strt_glitch    in   start checker: start bit sampled high
//   par_err        in   parity checker error
//   stp_err        in   stop checker error
//   edge_cnt_clr   out  holds the edge counter cleared (IDLE, DONE)
//   dat_samp_en    out  data sampler enable (inside a frame)
//   deser_en       out  deserializer shift strobe
//   strt_chk_en    out  start checker strobe
//   par_chk_en     out  parity checker strobe
//   stp_chk_en     out  stop checker strobe
//   data_valid     out  error-free byte ready, 1-cycle pulse
//   frame_err      out  stop bit error, 1-cycle pulse
//   parity_err     out  parity error, 1-cycle pulse
// ---------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int COUNTER_WIDTH  = 4,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [COUNTER_WIDTH-1:0]  bit_counter,
    input  logic [PRESCALE_WIDTH-1:0] sample_counter,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic                      edge_cnt_clr,
    output logic                      dat_samp_en,
    output logic                      deser_en,
    output logic                      strt_chk_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      data_valid,
    output logic                      frame_err,
    output logic                      parity_err
);

    logic [2:0] state_q, state_d;
    logic       par_en_q, par_en_d;
    logic       par_flag_q, par_flag_d;
    logic       stp_flag_q, stp_flag_d;

    logic [PRESCALE_WIDTH-1:0] be_val;
    logic [PRESCALE_WIDTH-1:0] sp_val;
    logic                      bit_end;
    logic                      samp_pt;
    logic                      err_window;
    logic [COUNTER_WIDTH-1:0]  stop_idx;

    // ------------------------------------------------------------------
    // Next-state, flag update and output decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        par_en_d     = par_en_q;
        par_flag_d   = par_flag_q;
        stp_flag_d   = stp_flag_q;
        edge_cnt_clr = 1'b0;
        dat_samp_en  = 1'b0;
        deser_en     = 1'b0;
        strt_chk_en  = 1'b0;
        par_chk_en   = 1'b0;
        stp_chk_en   = 1'b0;
        data_valid   = 1'b0;
        frame_err    = 1'b0;
        parity_err   = 1'b0;

        // Bit end is the last sample of a bit; the sample point sits two
        // samples past mid-bit so the line has settled.
        be_val     = Prescale - PRESCALE_WIDTH'(1);
        sp_val     = (Prescale >> 1) + PRESCALE_WIDTH'(2);
        bit_end    = (sample_counter == be_val);
        samp_pt    = (sample_counter == sp_val);
        // Checkers answer the cycle after their strobe, so error inputs are
        // only trusted from SP+1 up to the end of the bit.
        err_window = (sample_counter > sp_val) && (sample_counter <= be_val);
        stop_idx   = COUNTER_WIDTH'(PARITY_BIT_IDX) + COUNTER_WIDTH'(par_en_q);

        case (state_q)
            S_IDLE: begin
                edge_cnt_clr = 1'b1;
                if (!RX_IN) begin
                    state_d    = S_START;
                    par_en_d   = PAR_EN;
                    par_flag_d = 1'b0;
                    stp_flag_d = 1'b0;
                end
            end

            S_START: begin
                dat_samp_en = 1'b1;
                strt_chk_en = samp_pt;
                if (bit_end && bit_counter == COUNTER_WIDTH'(START_BIT_IDX)) begin
                    state_d = strt_glitch ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = samp_pt;
                if (bit_end && bit_counter == COUNTER_WIDTH'(DATA_BITS)) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end

            S_PARITY: begin
                dat_samp_en = 1'b1;
                par_chk_en  = samp_pt;
                if (err_window && par_err) begin
                    par_flag_d = 1'b1;
                end
                if (bit_end && bit_counter == COUNTER_WIDTH'(PARITY_BIT_IDX)) begin
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                dat_samp_en = 1'b1;
                stp_chk_en  = samp_pt;
                if (err_window && stp_err) begin
                    stp_flag_d = 1'b1;
                end
                if (bit_end && bit_counter == stop_idx) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                edge_cnt_clr = 1'b1;
                data_valid   = !par_flag_q && !stp_flag_q;
                parity_err   = par_flag_q;
                frame_err    = stp_flag_q;
                // A start edge already present here begins the next frame
                // without an idle cycle in between.
                if (!RX_IN) begin
                    state_d    = S_START;
                    par_en_d   = PAR_EN;
                    par_flag_d = 1'b0;
                    stp_flag_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Runaway guard: with an unsupported Prescale the bit landmarks may
        // never line up, so give up once the bit index overshoots any frame.
        if (state_q != S_IDLE && bit_end &&
            bit_counter > COUNTER_WIDTH'(GUARD_BIT_IDX)) begin
            state_d = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State and flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (RST) begin
            state_q    <= S_IDLE;
            par_en_q   <= 1'b0;
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            par_en_q   <= par_en_d;
            par_flag_q <= par_flag_d;
            stp_flag_q <= stp_flag_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Drives uart_rx_ctrl with an edge-counter model and frame-level stimulus,
// and compares every cycle against a reference that reasons purely in frame
// time: position t within the frame, bit = t / Prescale, sample = t % Prescale.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int CW = 4;
    localparam int PW = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic          PAR_EN;
    logic [PW-1:0] Prescale;
    logic [CW-1:0] bit_counter;
    logic [PW-1:0] sample_counter;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic          edge_cnt_clr, dat_samp_en, deser_en;
    logic          strt_chk_en, par_chk_en, stp_chk_en;
    logic          data_valid, frame_err, parity_err;

    always #5 CLK = ~CLK;

    uart_rx_ctrl #(.COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .RX_IN          (RX_IN),
        .PAR_EN         (PAR_EN),
        .Prescale       (Prescale),
        .bit_counter    (bit_counter),
        .sample_counter (sample_counter),
        .strt_glitch    (strt_glitch),
        .par_err        (par_err),
        .stp_err        (stp_err),
        .edge_cnt_clr   (edge_cnt_clr),
        .dat_samp_en    (dat_samp_en),
        .deser_en       (deser_en),
        .strt_chk_en    (strt_chk_en),
        .par_chk_en     (par_chk_en),
        .stp_chk_en     (stp_chk_en),
        .data_valid     (data_valid),
        .frame_err      (frame_err),
        .parity_err     (parity_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Edge counter model state (external block the controller steers).
    int   p_cur    = 8;
    int   sc       = 0;
    int   bc       = 0;
    logic clr_seen = 1'b1;

    // Reference: frame position and latched results.
    logic m_busy = 1'b0;
    int   m_t    = 0;
    logic m_pe   = 1'b0;
    logic m_pf   = 1'b0;
    logic m_sf   = 1'b0;

    // Observed pulse tallies for the directed literal checks.
    int c_deser, c_deser_off, c_dv, c_perr, c_ferr, c_samp, c_clr, c_strt, c_parchk;
    logic [8:0] obs;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic clear_counts();
        c_deser = 0; c_deser_off = 0; c_dv = 0; c_perr = 0; c_ferr = 0;
        c_samp = 0; c_clr = 0; c_strt = 0; c_parchk = 0;
    endtask

    // One clock cycle: update the edge counter, apply inputs, compare all
    // outputs against the reference, then advance the reference.
    // Output vector: {clr, samp, deser, strt, par_chk, stp_chk, dv, ferr, perr}
    task automatic cycle(input logic rx, input logic pen, input logic sg,
                         input logic pe_i, input logic se_i, input logic rst);
        logic [8:0] exp;
        int L, sp, b, s;
        @(negedge CLK);
        if (clr_seen) begin
            sc = 0; bc = 0;
        end else if (sc == p_cur - 1) begin
            sc = 0; bc = (bc + 1) % 16;
        end else begin
            sc = sc + 1;
        end
        sample_counter = PW'(sc);
        bit_counter    = CW'(bc);
        Prescale       = PW'(p_cur);
        RX_IN = rx; PAR_EN = pen; strt_glitch = sg; par_err = pe_i; stp_err = se_i; RST = rst;
        #1;
        L  = p_cur * (10 + int'(m_pe));
        sp = p_cur / 2 + 2;
        b  = m_t / p_cur;
        s  = m_t % p_cur;
        exp = '0;
        if (!m_busy) begin
            exp[8] = 1'b1;
        end else if (m_t == L) begin
            exp[8] = 1'b1;
            exp[2] = !(m_pf || m_sf);
            exp[1] = m_sf;
            exp[0] = m_pf;
        end else begin
            exp[7] = 1'b1;
            if (s == sp) begin
                if (b == 0)                exp[5] = 1'b1;
                else if (b <= 8)           exp[6] = 1'b1;
                else if (m_pe && b == 9)   exp[4] = 1'b1;
                else                       exp[3] = 1'b1;
            end
        end
        obs = {edge_cnt_clr, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
               stp_chk_en, data_valid, frame_err, parity_err};
        check($sformatf("outputs@cyc%0d", cyc), obs, exp);

        c_deser  += int'(deser_en);
        c_deser_off += int'(deser_en && sample_counter != PW'(p_cur / 2 + 2));
        c_dv     += int'(data_valid);
        c_perr   += int'(parity_err);
        c_ferr   += int'(frame_err);
        c_samp   += int'(dat_samp_en);
        c_clr    += int'(edge_cnt_clr);
        c_strt   += int'(strt_chk_en);
        c_parchk += int'(par_chk_en);
        clr_seen = edge_cnt_clr;

        // Advance the reference by one cycle.
        if (rst) begin
            m_busy = 1'b0; m_pe = 1'b0; m_pf = 1'b0; m_sf = 1'b0;
        end else if (!m_busy || m_t == L) begin
            if (!rx) begin
                m_busy = 1'b1; m_t = 0; m_pe = pen; m_pf = 1'b0; m_sf = 1'b0;
            end else begin
                m_busy = 1'b0;
            end
        end else begin
            if (m_pe && b == 9 && s > sp && pe_i) m_pf = 1'b1;
            if (b == 9 + int'(m_pe) && s > sp && se_i) m_sf = 1'b1;
            if (m_t == p_cur - 1 && sg) m_busy = 1'b0;
            else m_t = m_t + 1;
        end
        cyc++;
        if (cyc > 90000) begin
            $display("FAIL cycle_budget: got %0d cycles, limit 90000", cyc);
            $fatal(1, "cycle budget exceeded");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Full frame. lead: emit the IDLE cycle that sees the start edge.
    // b2b: hold the line low in DONE so the next frame starts at once.
    task automatic send_frame(input logic [7:0] d, input logic pen,
                              input logic perr, input logic serr,
                              input logic toggle, input logic lead,
                              input logic b2b, input logic next_pen,
                              input logic noise);
        int L, sp, b, s;
        logic rx, pe_d, se_d, sg_d;
        L  = p_cur * (10 + int'(pen));
        sp = p_cur / 2 + 2;
        if (lead) cycle(1'b0, pen, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < L; t++) begin
            b = t / p_cur;
            s = t % p_cur;
            if (b == 0)               rx = 1'b0;
            else if (b <= 8)          rx = d[b-1];
            else if (pen && b == 9)   rx = ^d;
            else                      rx = 1'b1;
            pe_d = perr && pen && b == 9 && s >= sp;
            se_d = serr && b == 9 + int'(pen) && s >= sp;
            sg_d = 1'b0;
            if (noise) begin
                pe_d = pe_d | ($urandom_range(0, 3) == 0);
                se_d = se_d | ($urandom_range(0, 3) == 0);
                sg_d = (b >= 1) && ($urandom_range(0, 1) == 0);
            end
            cycle(rx, (toggle && t >= L / 2) ? !pen : pen, sg_d, pe_d, se_d, 1'b0);
        end
        cycle(b2b ? 1'b0 : 1'b1, next_pen, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic b2b_prev;
        logic pen_next;
        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; strt_glitch = 1'b0;
        par_err = 1'b0; stp_err = 1'b0; Prescale = PW'(8);
        bit_counter = '0; sample_counter = '0;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_outputs", obs, 9'h100);
        idle(2);

        // Prescale 8, no parity, 0xA5
        p_cur = 8;
        clear_counts();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("a5_deser_pulses", c_deser, 8);
        check("a5_deser_off_sp", c_deser_off, 0);
        check("a5_data_valid", c_dv, 1);
        check("a5_errors", c_perr + c_ferr, 0);
        check("a5_frame_cycles", c_samp, 80);
        idle(3);

        // Prescale 16, parity enabled, parity error reported
        p_cur = 16;
        clear_counts();
        send_frame(8'h5B, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("par_parity_err", c_perr, 1);
        check("par_data_valid", c_dv, 0);
        check("par_chk_pulses", c_parchk, 1);
        check("par_frame_cycles", c_samp, 176);
        idle(3);

        // Start glitch: line low 3 cycles, then high
        p_cur = 8;
        clear_counts();
        for (int i = 0; i < 12; i++) cycle(i < 3 ? 1'b0 : 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("glitch_deser", c_deser, 0);
        check("glitch_frame_cycles", c_samp, 8);
        check("glitch_strt_chk", c_strt, 1);
        check("glitch_idle_after", obs[8], 1);
        idle(2);

        // Back-to-back 0x00, 0xFF
        clear_counts();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b_data_valid", c_dv, 2);
        check("b2b_frame_cycles", c_samp, 160);
        check("b2b_clear_cycles", c_clr, 3);
        idle(2);

        // Stop error, PAR_EN toggled mid-frame
        clear_counts();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stp_frame_err", c_ferr, 1);
        check("stp_data_valid", c_dv, 0);
        check("stp_frame_cycles", c_samp, 80);
        check("stp_par_chk", c_parchk, 0);
        idle(2);

        // Reset in DATA at bit_counter 4
        clear_counts();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 34; t++) cycle(t < 8 ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_bit_index", bc, 4);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_clear_next", obs[8], 1);
        idle(4);
        check("rst_no_pulses", c_dv + c_perr + c_ferr, 0);
        clear_counts();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_next_frame_valid", c_dv, 1);
        idle(2);

        // Randomized frames with checker noise
        b2b_prev = 1'b0;
        pen_next = $urandom_range(0, 1) == 1;
        for (int f = 0; f < 30; f++) begin
            logic pen, b2b;
            pen = pen_next;
            if (!b2b_prev) begin
                p_cur = ($urandom_range(0, 1) == 1) ? 16 : 8;
                idle($urandom_range(0, 3));
            end
            b2b      = $urandom_range(0, 2) == 0;
            pen_next = $urandom_range(0, 1) == 1;
            send_frame(8'($urandom), pen, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       !b2b_prev, b2b, pen_next, 1'b1);
            b2b_prev = b2b;
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
